uart_core: RTL and testbench

// - Next-generation full-duplex UART: one shared baud generator, 16x-oversampled receiver, transmitter.
// - Sits between a byte-stream client (valid/ready handshakes) and the rx/tx pins.
// - Generalises the fixed 8N1 controller: configurable frame, parity, stop bits, and error reporting.
// - Optional receive FIFO.

---
 rtl/uart_core.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with one shared 16x baud tick, an oversampling
// receiver and a transmitter. Frame format (data bits, parity, stop bits) is
// set by parameters; parity/frame errors and overruns are reported as pulses.
// Build option: define UART_RX_FIFO_EN to replace the single receive holding
// register with an RX_FIFO_DEPTH-entry first-word-fall-through FIFO.
module uart_core #(
   parameter int CLK_FREQ      = 50_000_000,
   parameter int BAUD          = 115_200,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   output logic                 tx_o,
   input  logic [DATA_BITS-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic [DATA_BITS-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 overrun_o
);

   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic [4:0]    STOP_LAST = 5'(STOP_BITS * 16 - 1);

   // Reject configurations the counters are not sized for.
   if (DIV < 2) begin : g_bad_div
      $error("uart_core: CLK_FREQ/(BAUD*16) must be >= 2");
   end
   if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_core: RX_FIFO_DEPTH must be a power of 2 >= 2");
   end

   // Parity bit that makes the frame's count of ones odd (1) or even (2).
   function automatic logic par_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == 1) ? ~^d : ^d;
   endfunction

   // ---------------------------------------------------------------- baud tick
   logic [CW-1:0] baud_q;
   logic          tick;

   assign tick = (baud_q == CW'(DIV - 1));

   // Free-running divider shared by both directions.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) baud_q <= '0;
      else         baud_q <= tick ? '0 : baud_q + CW'(1);
   end

   // ---------------------------------------------------------------- transmit
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

   tx_state_e            tx_state_q, tx_state_d;
   logic [4:0]           tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;

   // Transmit state, shift register and registered line output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
      end
   end

   // Transmit sequencing: each bit is held for 16 ticks; the line level for
   // the next bit is chosen on the transition so tx stays glitch-free.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      unique case (tx_state_q)
         TX_IDLE: begin
            tx_d = 1'b1;
            if (tx_valid_i) begin
               tx_state_d = TX_START;
               tx_sh_d    = tx_data_i;
               tx_par_d   = par_of(tx_data_i);
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_d       = 1'b0;
            end
         end
         TX_START: if (tick) begin
            if (tx_cnt_q == 5'd15) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
               tx_d       = tx_sh_q[0];
            end else tx_cnt_d = tx_cnt_q + 5'd1;
         end
         TX_DATA: if (tick) begin
            if (tx_cnt_q == 5'd15) begin
               tx_cnt_d = '0;
               if (tx_bit_q == BIT_LAST) begin
                  if (PARITY != 0) begin
                     tx_state_d = TX_PAR;
                     tx_d       = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     tx_d       = 1'b1;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + BW'(1);
                  tx_sh_d  = tx_sh_q >> 1;
                  tx_d     = tx_sh_q[1];
               end
            end else tx_cnt_d = tx_cnt_q + 5'd1;
         end
         TX_PAR: if (tick) begin
            if (tx_cnt_q == 5'd15) begin
               tx_state_d = TX_STOP;
               tx_cnt_d   = '0;
               tx_d       = 1'b1;
            end else tx_cnt_d = tx_cnt_q + 5'd1;
         end
         TX_STOP: if (tick) begin
            if (tx_cnt_q == STOP_LAST) begin
               tx_state_d = TX_IDLE;
               tx_cnt_d   = '0;
            end else tx_cnt_d = tx_cnt_q + 5'd1;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign tx_o       = tx_q;
   assign tx_ready_o = (tx_state_q == TX_IDLE);

   // ---------------------------------------------------------------- receive
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_e;

   logic [1:0]           rx_sync_q;
   logic                 rx_s;
   rx_state_e            rx_state_q, rx_state_d;
   logic [3:0]           rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_par_q, rx_par_d;
   logic                 done_q, done_d;
   logic                 done_pe_q, done_pe_d;
   logic                 done_fe_q, done_fe_d;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rx_sync_q <= 2'b11;
      else         rx_sync_q <= {rx_sync_q[0], rx_i};
   end

   assign rx_s = rx_sync_q[1];

   // Receive state, sample shift register and the one-clock frame-done flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_par_q   <= 1'b0;
         done_q     <= 1'b0;
         done_pe_q  <= 1'b0;
         done_fe_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_par_q   <= rx_par_d;
         done_q     <= done_d;
         done_pe_q  <= done_pe_d;
         done_fe_q  <= done_fe_d;
      end
   end

   // Receive sequencing: confirm the start bit at its centre (8 ticks), then
   // sample every 16 ticks. A low stop bit parks in RX_BREAK until the line
   // returns high so a held-low line is not mistaken for new start bits.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_par_d   = rx_par_q;
      done_d     = 1'b0;
      done_pe_d  = 1'b0;
      done_fe_d  = 1'b0;
      unique case (rx_state_q)
         RX_IDLE: if (!rx_s) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
         end
         RX_START: if (tick) begin
            if (rx_cnt_q == 4'd7) begin
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
            end else rx_cnt_d = rx_cnt_q + 4'd1;
         end
         RX_DATA: if (tick) begin
            if (rx_cnt_q == 4'd15) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
               if (rx_bit_q == BIT_LAST) rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
               else                      rx_bit_d   = rx_bit_q + BW'(1);
            end else rx_cnt_d = rx_cnt_q + 4'd1;
         end
         RX_PAR: if (tick) begin
            if (rx_cnt_q == 4'd15) begin
               rx_cnt_d   = '0;
               rx_par_d   = rx_s;
               rx_state_d = RX_STOP;
            end else rx_cnt_d = rx_cnt_q + 4'd1;
         end
         RX_STOP: if (tick) begin
            if (rx_cnt_q == 4'd15) begin
               rx_cnt_d   = '0;
               done_d     = 1'b1;
               done_fe_d  = !rx_s;
               done_pe_d  = (PARITY != 0) && (rx_par_q != par_of(rx_sh_q));
               rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
            end else rx_cnt_d = rx_cnt_q + 4'd1;
         end
         RX_BREAK: if (rx_s) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- delivery
`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(RX_FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
   logic [AW:0]          wp_q, rp_q;
   logic                 pe_q, fe_q, ov_q;
   logic                 empty, full, rd, wr;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign rd    = !empty && rx_ready_i;
   // A read in the same clock frees the slot, so a full FIFO still accepts.
   assign wr    = done_q && (!full || rd);

   // FIFO storage, pointers and the error/overrun pulses tied to each write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
         wp_q <= '0;
         rp_q <= '0;
         pe_q <= 1'b0;
         fe_q <= 1'b0;
         ov_q <= 1'b0;
      end else begin
         pe_q <= wr && done_pe_q;
         fe_q <= wr && done_fe_q;
         ov_q <= done_q && !wr;
         if (wr) begin
            mem_q[wp_q[AW-1:0]] <= rx_sh_q;
            wp_q                <= wp_q + 1'b1;
         end
         if (rd) rp_q <= rp_q + 1'b1;
      end
   end

   assign rx_valid_o = !empty;
   assign rx_data_o  = mem_q[rp_q[AW-1:0]];
`else
   logic [DATA_BITS-1:0] hold_q;
   logic                 hv_q, pe_q, fe_q, ov_q;

   // Single holding register: a new byte is stored only if the slot is free
   // or being consumed this clock; otherwise it is dropped with an overrun.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= '0;
         hv_q   <= 1'b0;
         pe_q   <= 1'b0;
         fe_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         pe_q <= 1'b0;
         fe_q <= 1'b0;
         ov_q <= 1'b0;
         if (done_q) begin
            if (!hv_q || rx_ready_i) begin
               hold_q <= rx_sh_q;
               hv_q   <= 1'b1;
               pe_q   <= done_pe_q;
               fe_q   <= done_fe_q;
            end else ov_q <= 1'b1;
         end else if (hv_q && rx_ready_i) hv_q <= 1'b0;
      end
   end

   assign rx_valid_o = hv_q;
   assign rx_data_o  = hold_q;
`endif

   assign parity_err_o = pe_q;
   assign frame_err_o  = fe_q;
   assign overrun_o    = ov_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at CLK_FREQ=1.6 MHz, BAUD=10 kbit/s (DIV=10, 160 clk/bit).
// Two instances: "a" is 8N1 with a bench-driven rx line, "p" is 8E1 whose rx
// is either looped back from its own tx or driven by the bench.
module tb_uart_core;
   localparam int CF = 1_600_000;
   localparam int BD = 10_000;

   typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_rx = 1'b1, a_tx, a_txv = 1'b0, a_txr, a_rxv, a_rxr = 1'b1, a_pe, a_fe, a_ov;
   logic [7:0] a_txd = 8'h00, a_rxd;
   logic       p_lb = 1'b0, p_drv = 1'b1, p_rx, p_tx, p_txv = 1'b0, p_txr, p_rxv, p_pe, p_fe, p_ov;
   logic [7:0] p_txd = 8'h00, p_rxd;

   assign p_rx = p_lb ? p_tx : p_drv;

   uart_core #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(a_rx), .tx_o(a_tx),
      .tx_data_i(a_txd), .tx_valid_i(a_txv), .tx_ready_o(a_txr),
      .rx_data_o(a_rxd), .rx_valid_o(a_rxv), .rx_ready_i(a_rxr),
      .parity_err_o(a_pe), .frame_err_o(a_fe), .overrun_o(a_ov));

   uart_core #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_p (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(p_rx), .tx_o(p_tx),
      .tx_data_i(p_txd), .tx_valid_i(p_txv), .tx_ready_o(p_txr),
      .rx_data_o(p_rxd), .rx_valid_o(p_rxv), .rx_ready_i(1'b1),
      .parity_err_o(p_pe), .frame_err_o(p_fe), .overrun_o(p_ov));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected receive streams and observed side counts.
   exp_t       qa[$], qp[$];
   int         ov_a = 0, ov_p = 0, got_p = 0;
   logic [7:0] last_p = 8'h00;

   // Transmit model for instance a: accept time and frame bits in line order.
   int         cyc = 0, t0 = 0, te;
   logic       tx_act = 1'b0;
   logic [9:0] tx_frame = 10'h3FF;
   assign te = cyc - t0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       pa_v = 1'b0, pa_c = 1'b0, pp_v = 1'b0, pp_c = 1'b0;
   logic [7:0] pa_d = 8'h00, pp_d = 8'h00;

   // Compare process: each negedge, check presented bytes, error pulses,
   // held data and the tx waveform against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         pa_v <= 1'b0; pa_c <= 1'b0; pp_v <= 1'b0; pp_c <= 1'b0; tx_act <= 1'b0;
      end else begin
         // instance a receive
         if (a_rxv && (!pa_v || pa_c)) begin
            if (qa.size() == 0) chk("a_rx_unexpected", 32'd1, 32'd0);
            else begin
               chk("a_rx_data", {24'd0, a_rxd}, {24'd0, qa[0].d});
               chk("a_rx_errs", {30'd0, a_pe, a_fe}, {30'd0, qa[0].pe, qa[0].fe});
               qa.delete(0);
            end
         end else chk("a_err_stray", {30'd0, a_pe, a_fe}, 32'd0);
         if (a_rxv && pa_v && !pa_c) chk("a_rx_hold", {24'd0, a_rxd}, {24'd0, pa_d});
         if (a_ov) ov_a <= ov_a + 1;
         pa_v <= a_rxv; pa_c <= a_rxv && a_rxr; pa_d <= a_rxd;
         // instance p receive
         if (p_rxv && (!pp_v || pp_c)) begin
            if (qp.size() == 0) chk("p_rx_unexpected", 32'd1, 32'd0);
            else begin
               chk("p_rx_data", {24'd0, p_rxd}, {24'd0, qp[0].d});
               chk("p_rx_errs", {30'd0, p_pe, p_fe}, {30'd0, qp[0].pe, qp[0].fe});
               qp.delete(0);
            end
            got_p <= got_p + 1; last_p <= p_rxd;
         end else chk("p_err_stray", {30'd0, p_pe, p_fe}, 32'd0);
         if (p_rxv && pp_v && !pp_c) chk("p_rx_hold", {24'd0, p_rxd}, {24'd0, pp_d});
         if (p_ov) ov_p <= ov_p + 1;
         pp_v <= p_rxv; pp_c <= p_rxv; pp_d <= p_rxd;
         // instance a transmit: bit j spans te in [160j-9, 160j+151)
         if (a_txv && a_txr) begin
            tx_act <= 1'b1; t0 <= cyc + 1; tx_frame <= {1'b1, a_txd, 1'b0};
         end else if (tx_act) begin
            if (te < 1600 && (te % 160) >= 15 && (te % 160) <= 145)
               chk("a_tx_bit", {31'd0, a_tx}, {31'd0, tx_frame[te / 160]});
            if (te < 1585) chk("a_tx_ready_busy", {31'd0, a_txr}, 32'd0);
            if (te >= 1605) begin
               chk("a_tx_idle", {30'd0, a_tx, a_txr}, 32'd3);
               if (te >= 1700) tx_act <= 1'b0;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Drive a frame (bits in line order, LSB first) on a's rx or p's rx,
   // 160 clk per bit with a custom length for the last bit, then idle.
   task automatic drive(input bit which, input logic [15:0] bits, input int n, input int last_len);
      for (int i = 0; i < n; i++) begin
         if (which) p_drv = bits[i]; else a_rx = bits[i];
         step(i == n - 1 ? last_len : 160);
      end
      if (which) p_drv = 1'b1; else a_rx = 1'b1;
      step(200);
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] d);
      return {7'd0, 1'b1, d, 1'b0};
   endfunction

   function automatic logic [15:0] f8e1(input logic [7:0] d, input bit flip);
      return {5'd0, 1'b1, (^d) ^ flip, d, 1'b0};
   endfunction

   initial begin
      logic [9:0] lit;
      lit = 10'h34A;  // 0xA5 framed 8N1: line order 0,1,0,1,0,0,1,0,1,1
      // reset state
      rst_n = 1'b0;
      step(3);
      chk("rst_a_tx_txr", {30'd0, a_tx, a_txr}, 32'd3);
      chk("rst_a_rx", {23'd0, a_rxv, a_rxd}, 32'd0);
      chk("rst_a_pulses", {29'd0, a_pe, a_fe, a_ov}, 32'd0);
      chk("rst_p_state", {21'd0, p_tx, p_txr, p_rxv, p_rxd}, {21'd0, 3'b110, 8'h00});
      rst_n = 1'b1;
      step(20);

      // 8N1 transmit of 0xA5 with hand-computed bit-centre samples
      a_txd = 8'hA5; a_txv = 1'b1;
      step(1);
      a_txv = 1'b0; a_txd = 8'h00;
      for (int j = 0; j < 10; j++) begin
         step(j == 0 ? 80 : 160);
         chk("a5_bit", {31'd0, a_tx}, {31'd0, lit[j]});
         if (j == 4) chk("a5_ready_low", {31'd0, a_txr}, 32'd0);
      end
      step(90);
      chk("a5_ready_back", {30'd0, a_tx, a_txr}, 32'd3);

      // 8E1 loopback of 0x3C
      p_lb = 1'b1;
      qp.push_back(exp_t'{8'h3C, 1'b0, 1'b0});
      p_txd = 8'h3C; p_txv = 1'b1;
      step(1);
      p_txv = 1'b0;
      step(2000);
      chk("lb_count", got_p, 32'd1);
      chk("lb_data", {24'd0, last_p}, 32'h3C);
      p_lb = 1'b0;

      // 8E1 frame with a wrong parity bit
      qp.push_back(exp_t'{8'h3C, 1'b1, 1'b0});
      drive(1'b1, f8e1(8'h3C, 1'b1), 11, 160);
      chk("bad_par_count", got_p, 32'd2);

      // 0x55 with a stop bit held low for 320 clk, then a 40-clk glitch
      qa.push_back(exp_t'{8'h55, 1'b0, 1'b1});
      drive(1'b0, {7'd0, 1'b0, 8'h55, 1'b0}, 10, 320);
      a_rx = 1'b0;
      step(40);
      a_rx = 1'b1;
      step(300);
      chk("glitch_none", qa.size(), 32'd0);

      // overrun with the client stalled
      a_rxr = 1'b0;
`ifdef UART_RX_FIFO_EN
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) qa.push_back(exp_t'{8'(i * 17), 1'b0, 1'b0});
         drive(1'b0, f8n1(8'(i * 17)), 10, 160);
      end
      step(50);
      chk("ovr_count", ov_a, 32'd1);
      chk("ovr_head", {24'd0, a_rxd}, 32'h11);
`else
      qa.push_back(exp_t'{8'h11, 1'b0, 1'b0});
      drive(1'b0, f8n1(8'h11), 10, 160);
      drive(1'b0, f8n1(8'h22), 10, 160);
      step(50);
      chk("ovr_count", ov_a, 32'd1);
      chk("ovr_keep", {24'd0, a_rxd}, 32'h11);
`endif
      a_rxr = 1'b1;
      step(20);
      chk("ovr_drained", qa.size(), 32'd0);

      // reset mid-TX data bit and mid-RX byte (0xFF keeps the line high after)
      fork
         begin
            a_txd = 8'hA5; a_txv = 1'b1;
            step(1);
            a_txv = 1'b0;
         end
         drive(1'b0, f8n1(8'hFF), 10, 160);
         begin
            step(400);
            chk("pre_rst_tx_low", {31'd0, a_tx}, 32'd0);
            rst_n = 1'b0;
            #1;
            chk("rst_mid_tx", {30'd0, a_tx, a_txr}, 32'd3);
            chk("rst_mid_rxv", {31'd0, a_rxv}, 32'd0);
            step(3);
            rst_n = 1'b1;
         end
      join

      // next full frame after the reset
      qa.push_back(exp_t'{8'h3A, 1'b0, 1'b0});
      drive(1'b0, f8n1(8'h3A), 10, 160);
      step(100);
      chk("end_qa_empty", qa.size(), 32'd0);
      chk("end_qp_empty", qp.size(), 32'd0);
      chk("end_p_no_ovr", ov_p, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
